shift_deserializer: RTL

Serial-in/parallel-out receiver. It is the far end of the parallel-load shift register used as a serial transmitter.
- Collects N serial bits, MSB-first or LSB-first, into a word.
- Matches the transmitter's shift-left mode (MSB leaves first) and shift-right mode (LSB leaves first).
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Sits between a serial link and downstream word-wide logic.

---
 rtl/shift_deserializer.sv | 113 +++++++++++
 1 files changed

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver with a valid/ready word output and a sticky overrun flag.
// Optional even-parity trailer bit: define SHIFT_DESERIALIZER_PARITY_CHECK_EN.
module shift_deserializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sdi,
    input  logic         sdi_valid,
    input  logic         frame_start,
    input  logic         dir,
    output logic [N-1:0] Out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
`ifdef SHIFT_DESERIALIZER_PARITY_CHECK_EN
    output logic         parity_err,
`endif
    output logic         overrun
);
    localparam int CW = $clog2(N + 1);

`ifdef SHIFT_DESERIALIZER_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic perr_q, perr_d;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t        state_q;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [N-1:0]  out_q, word_d;
    logic [CW-1:0] cnt_q;
    logic          dir_q, out_valid_q, overrun_q;
    logic          start, use_lsb, last_bit, done;

    always_comb begin
        start    = sdi_valid && frame_start;
        use_lsb  = start ? dir : dir_q;
        shreg_d  = use_lsb ? {sdi, shreg_q[N-1:1]} : {shreg_q[N-2:0], sdi};
        last_bit = (state_q == SHIFT) && sdi_valid && !frame_start && (cnt_q == CW'(N - 1));
`ifdef SHIFT_DESERIALIZER_PARITY_CHECK_EN
        // The data word is already complete in shreg; the current bit is the parity trailer.
        done     = (state_q == PARITY) && sdi_valid && !frame_start;
        word_d   = shreg_q;
        perr_d   = (^shreg_q) ^ sdi;
`else
        done     = last_bit;
        word_d   = shreg_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_CHECK_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            // frame_start wins in every state: a resync silently drops any partial word.
            if (start) begin
                shreg_q <= shreg_d;
                dir_q   <= dir;
                cnt_q   <= CW'(1);
                state_q <= SHIFT;
            end else begin
                case (state_q)
                    SHIFT: if (sdi_valid) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_q + CW'(1);
`ifdef SHIFT_DESERIALIZER_PARITY_CHECK_EN
                        if (last_bit) state_q <= PARITY;
`else
                        if (last_bit) state_q <= IDLE;
`endif
                    end
`ifdef SHIFT_DESERIALIZER_PARITY_CHECK_EN
                    PARITY: if (sdi_valid) state_q <= IDLE;
`endif
                    default: state_q <= IDLE;
                endcase
            end

            if (done) begin
                if (!out_valid_q || out_ready) begin
                    out_q       <= word_d;
                    out_valid_q <= 1'b1;
`ifdef SHIFT_DESERIALIZER_PARITY_CHECK_EN
                    perr_q      <= perr_d;
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign Out        = out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);
`ifdef SHIFT_DESERIALIZER_PARITY_CHECK_EN
    assign parity_err = perr_q;
`endif
endmodule
